// File: rtl/seg_word_decoder.sv
// seg_word_decoder
// Loopback monitor for the rotating 3-digit "dE1" display driver.
// - Samples the three active-low 7-segment buses on every clock.
// - Waits for the sampled word to hold steady.
// - Decodes each glyph back to its character code.
// - Reports which rotation of the reference word is being shown.
//
// state  | meaning
// IDLE   | just out of reset; first edge moves to SETTLE with cnt=0
// SETTLE | counting identical consecutive samples toward acceptance
// LOCKED | word accepted; outputs held until the sample changes
module seg_word_decoder #(
  parameter int         STABLE_CYCLES = 4,
  parameter int         CNT_W         = 8,
  parameter logic [1:0] REF_C1        = 2'd0,
  parameter logic [1:0] REF_C2        = 2'd1,
  parameter logic [1:0] REF_C3        = 2'd2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       seg2_n,
  input  logic [6:0]       seg1_n,
  input  logic [6:0]       seg0_n,
  output logic [1:0]       code2,
  output logic [1:0]       code1,
  output logic [1:0]       code0,
  output logic [1:0]       sel_out,
  output logic             match,
  output logic             bad_char,
  output logic             word_valid,
  output logic             word_strobe,
  output logic [CNT_W-1:0] change_count
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  state_t      state_q;
  logic [20:0] samp_q;
  logic [20:0] samp_d;
  logic [CW-1:0] cnt_q;
  logic        same;

  logic [1:0]  dec2, dec1, dec0;
  logic        inv2, inv1, inv0;
  logic [1:0]  sel_d;
  logic        match_d;
  logic        bad_d;
  logic        word_changed;

  // {invalid, code} for one active-low glyph
  function automatic logic [2:0] glyph_decode(input logic [6:0] g);
    logic [2:0] r;
    case (g)
      GLYPH_D:     r = 3'b0_00;
      GLYPH_E:     r = 3'b0_01;
      GLYPH_1:     r = 3'b0_10;
      GLYPH_BLANK: r = 3'b0_11;
      default:     r = 3'b1_11;
    endcase
    return r;
  endfunction

  assign samp_d = {seg2_n, seg1_n, seg0_n};
  assign same   = (samp_d == samp_q);

  // Decode the held sample; on the accepting edge it equals the new sample.
  always_comb begin
    {inv2, dec2} = glyph_decode(samp_q[20:14]);
    {inv1, dec1} = glyph_decode(samp_q[13:7]);
    {inv0, dec0} = glyph_decode(samp_q[6:0]);
    sel_d   = 2'd3;
    match_d = 1'b0;
    bad_d   = 1'b0;
    if (inv2 || inv1 || inv0) begin
      bad_d = 1'b1;
    end else if ({dec2, dec1, dec0} == {REF_C1, REF_C2, REF_C3}) begin
      sel_d   = 2'd0;
      match_d = 1'b1;
    end else if ({dec2, dec1, dec0} == {REF_C3, REF_C1, REF_C2}) begin
      sel_d   = 2'd1;
      match_d = 1'b1;
    end else if ({dec2, dec1, dec0} == {REF_C2, REF_C3, REF_C1}) begin
      sel_d   = 2'd2;
      match_d = 1'b1;
    end else if (samp_q == {3{GLYPH_BLANK}}) begin
      match_d = 1'b1;
    end
    // The held code registers double as the previously accepted triple.
    word_changed = ({dec2, dec1, dec0} != {code2, code1, code0});
  end

  // Sampling, stability FSM and registered result outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      samp_q       <= {3{GLYPH_BLANK}};
      cnt_q        <= '0;
      code2        <= 2'b11;
      code1        <= 2'b11;
      code0        <= 2'b11;
      sel_out      <= 2'b11;
      match        <= 1'b0;
      bad_char     <= 1'b0;
      word_valid   <= 1'b0;
      word_strobe  <= 1'b0;
      change_count <= '0;
    end else begin
      samp_q      <= samp_d;
      word_strobe <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= SETTLE;
          cnt_q   <= '0;
        end
        SETTLE: begin
          if (!same) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= LOCKED;
            word_valid  <= 1'b1;
            word_strobe <= 1'b1;
            code2       <= dec2;
            code1       <= dec1;
            code0       <= dec0;
            sel_out     <= sel_d;
            match       <= match_d;
            bad_char    <= bad_d;
            if (word_changed && (change_count != {CNT_W{1'b1}}))
              change_count <= change_count + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!same) begin
            state_q    <= SETTLE;
            cnt_q      <= '0;
            word_valid <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_word_decoder.sv
// Self-checking bench for seg_word_decoder: a run-length behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_seg_word_decoder;

  localparam int SC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] s2 = 7'h7F, s1 = 7'h7F, s0 = 7'h7F;
  logic [6:0] t2 = 7'h7F, t1 = 7'h7F, t0 = 7'h7F;

  logic [1:0] code2, code1, code0, sel_out;
  logic       match, bad_char, word_valid, word_strobe;
  logic [7:0] change_count;

  logic [1:0] code2_b, code1_b, code0_b, sel_out_b;
  logic       match_b, bad_char_b, word_valid_b, word_strobe_b;
  logic [1:0] change_count_b;

  int tests = 0;
  int fails = 0;

  seg_word_decoder #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .seg2_n(s2), .seg1_n(s1), .seg0_n(s0),
    .code2(code2), .code1(code1), .code0(code0),
    .sel_out(sel_out), .match(match), .bad_char(bad_char),
    .word_valid(word_valid), .word_strobe(word_strobe),
    .change_count(change_count)
  );

  seg_word_decoder #(.STABLE_CYCLES(SC), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset),
    .seg2_n(t2), .seg1_n(t1), .seg0_n(t0),
    .code2(code2_b), .code1(code1_b), .code0(code0_b),
    .sel_out(sel_out_b), .match(match_b), .bad_char(bad_char_b),
    .word_valid(word_valid_b), .word_strobe(word_strobe_b),
    .change_count(change_count_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A word is accepted once the same sample has been seen on SC+1
  // consecutive edges since reset or since the last change.
  int         run;
  logic [20:0] last;
  logic [1:0] mc[3];
  logic [1:0] m_sel;
  logic       m_match, m_bad, m_valid, m_strobe;
  int         m_cnt;

  function automatic logic [2:0] glyph(input logic [6:0] g);
    case (g)
      7'h21:   return 3'b000;
      7'h06:   return 3'b001;
      7'h79:   return 3'b010;
      7'h7F:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  task automatic model_accept(input logic [6:0] g2, input logic [6:0] g1, input logic [6:0] g0);
    logic [6:0] g[3];
    logic [1:0] c[3];
    logic [1:0] refs[3];
    logic       inv, blank;
    int         ns, nm;
    g[2] = g2; g[1] = g1; g[0] = g0;
    refs[0] = 2'd0; refs[1] = 2'd1; refs[2] = 2'd2;
    inv = 1'b0; blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [2:0] d;
      d = glyph(g[i]);
      c[i] = d[1:0];
      if (d[2]) inv = 1'b1;
      if (g[i] != 7'h7F) blank = 1'b0;
    end
    ns = 3; nm = 0;
    if (!inv) begin
      for (int r = 2; r >= 0; r--)
        if (c[2] == refs[(3 - r) % 3] && c[1] == refs[(4 - r) % 3] && c[0] == refs[(5 - r) % 3]) begin
          ns = r; nm = 1;
        end
      if (nm == 0 && blank) nm = 1;
    end
    if ((c[2] != mc[2] || c[1] != mc[1] || c[0] != mc[0]) && m_cnt < 255) m_cnt++;
    mc[2] = c[2]; mc[1] = c[1]; mc[0] = c[0];
    m_sel = 2'(ns); m_match = (nm != 0); m_bad = inv;
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      run = 0; last = '0;
      mc[0] = 2'd3; mc[1] = 2'd3; mc[2] = 2'd3;
      m_sel = 2'd3; m_match = 1'b0; m_bad = 1'b0;
      m_valid = 1'b0; m_strobe = 1'b0; m_cnt = 0;
    end else begin
      if (run > 0 && {s2, s1, s0} == last) begin
        if (run < 1000) run++;
      end else begin
        run = 1;
      end
      last = {s2, s1, s0};
      m_valid  = (run >= SC + 1);
      m_strobe = (run == SC + 1);
      if (m_strobe) model_accept(s2, s1, s0);
    end
  end

  bit started = 1'b0;
  initial forever begin
    @(negedge clock);
    if (started) begin
      chk("m_code2", code2, mc[2]);
      chk("m_code1", code1, mc[1]);
      chk("m_code0", code0, mc[0]);
      chk("m_sel", sel_out, m_sel);
      chk("m_match", match, m_match);
      chk("m_bad", bad_char, m_bad);
      chk("m_valid", word_valid, m_valid);
      chk("m_strobe", word_strobe, m_strobe);
      chk("m_count", change_count, m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set1(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    s2 = a; s1 = b; s0 = c;
  endtask

  task automatic wait_strobe(input bit b, output int n);
    logic st;
    n = 0; st = 1'b0;
    while (n < 40 && st !== 1'b1) begin
      @(posedge clock);
      @(negedge clock);
      n++;
      st = b ? word_strobe_b : word_strobe;
    end
    chk(b ? "strobe_b_seen" : "strobe_seen", st, 1'b1);
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    started = 1'b1;
    reset = 1'b0;

    // 1: blank word accepted after edge 4
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("t1_no_early_strobe", word_strobe, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("t1_strobe", word_strobe, 1'b1);
    chk("t1_sel", sel_out, 2'd3);
    chk("t1_match", match, 1'b1);
    chk("t1_codes", {code2, code1, code0}, 6'b11_11_11);
    chk("t1_count", change_count, 8'd0);

    // 2: the three rotations
    set1(7'h21, 7'h06, 7'h79);
    wait_strobe(1'b0, n);
    chk("t2_latency", n, SC + 1);
    chk("t2a_codes", {code2, code1, code0}, 6'b00_01_10);
    chk("t2a_sel", sel_out, 2'd0);
    chk("t2a_match", match, 1'b1);
    chk("t2a_count", change_count, 8'd1);
    set1(7'h79, 7'h21, 7'h06);
    wait_strobe(1'b0, n);
    chk("t2b_sel", sel_out, 2'd1);
    chk("t2b_count", change_count, 8'd2);
    set1(7'h06, 7'h79, 7'h21);
    wait_strobe(1'b0, n);
    chk("t2c_sel", sel_out, 2'd2);
    chk("t2c_count", change_count, 8'd3);

    // 3: two-cycle glitch returning to the accepted word
    set1(7'h21, 7'h06, 7'h79);
    wait_strobe(1'b0, n);
    chk("t3_count_pre", change_count, 8'd4);
    s1 = 7'h00;
    @(posedge clock);
    @(negedge clock);
    chk("t3_valid_drop", word_valid, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("t3_valid_low2", word_valid, 1'b0);
    s1 = 7'h06;
    wait_strobe(1'b0, n);
    chk("t3_restrobe_latency", n, SC + 1);
    chk("t3_count_same", change_count, 8'd4);
    chk("t3_sel", sel_out, 2'd0);

    // 4: undecodable glyph held
    s1 = 7'h00;
    wait_strobe(1'b0, n);
    chk("t4_bad", bad_char, 1'b1);
    chk("t4_match", match, 1'b0);
    chk("t4_code1", code1, 2'd3);
    chk("t4_code2", code2, 2'd0);
    chk("t4_sel", sel_out, 2'd3);
    chk("t4_count", change_count, 8'd5);

    // 5: asynchronous reset in mid-SETTLE
    set1(7'h21, 7'h06, 7'h79);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t5_codes", {code2, code1, code0}, 6'b11_11_11);
    chk("t5_sel", sel_out, 2'd3);
    chk("t5_match", match, 1'b0);
    chk("t5_bad", bad_char, 1'b0);
    chk("t5_valid", word_valid, 1'b0);
    chk("t5_strobe", word_strobe, 1'b0);
    chk("t5_count", change_count, 8'd0);
    @(negedge clock);
    set1(7'h7F, 7'h7F, 7'h7F);
    reset = 1'b0;

    // 6: narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin t2 = 7'h21; t1 = 7'h06; t0 = 7'h79; end
      else            begin t2 = 7'h79; t1 = 7'h21; t0 = 7'h06; end
      wait_strobe(1'b1, n);
      chk("t6_count_b", change_count_b, (i + 1 > 3) ? 3 : i + 1);
      chk("t6_sel_b", sel_out_b, (i % 2 == 0) ? 2'd0 : 2'd1);
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
